conv2_relu_pool: RTL and testbench
==================================

# conv2_relu_pool

Post-processing stage directly downstream of each conv2 channel-sum calculator. Consumes the 14-bit signed convolution sum stream in raster order, optionally adds a per-channel bias, applies ReLU, and performs 2×2 stride-2 max pooling. Each 8×8 conv2 output map is reduced to a 4×4 map of 12-bit values that feed the fully-connected layer. One instance is built per conv2 output channel.

## Interface
- `IN_W`, default 14: width of the signed input sum.
- `OUT_W`, default 12: width of the pooled output.
- `ROW_LEN`, default 8: conv2 output map width; must be even.
- `COL_LEN`, default 8: conv2 output map height; must be even.
- `BIAS`, default 0: signed 14-bit channel bias; used only when `CONV2_BIAS_EN` is defined.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `valid_in`  in  1  `conv_in` holds a valid pixel this cycle. Connects to the calc stage's `valid_out_calc`.
- `conv_in`  in  IN_W  signed convolution sum for the current pixel.
- `data_out`  out  OUT_W  signed pooled value; always in the range 0..2^(OUT_W-1)-1.
- `valid_out`  out  1  one-cycle strobe; `data_out` is valid.
- `frame_done`  out  1  one-cycle strobe, coincident with the last pooled output of a map.

## Operation
- **Stage 1 (registered):**
  - sum = `conv_in` + BIAS, computed IN_W+1 bits wide and signed.
  - relu = 0 if sum < 0, otherwise sum.
  - The result and a stage-1 valid flag are registered.
- **Counters:**
  - Column counter `x` (0..ROW_LEN-1) and row counter `y` (0..COL_LEN-1) advance once per stage-1 valid pixel.
  - `x` wraps to 0 and increments `y`. `y` wraps to 0 after the last row.
  - The block is therefore ready for the next map with no gap.
- **Line buffer:** ROW_LEN/2 entries, each IN_W bits, indexed by `x>>1`.
- **Even row `y`:**
  - Even `x`: hold = relu.
  - Odd `x`: linebuf[x>>1] = max(hold, relu).
  - No output on even rows.
- **Odd row `y`:**
  - Even `x`: hold = max(linebuf[x>>1], relu).
  - Odd `x`: emit max(hold, relu).
- **Output saturation:** the emitted value saturates to 2^(OUT_W-1)-1 (2047 by default) when larger. It is then registered into `data_out` and `valid_out` is pulsed.
- **`frame_done`:** pulses with the output for `x`=ROW_LEN-1, `y`=COL_LEN-1.
- **Non-valid cycles:** counters, hold, and line buffer are unchanged. `data_out` holds its last value and `valid_out`=0.
- **Backpressure:** none; the downstream stage must accept every strobe.
- **Reset (any time, including mid-frame):**
  - `x`, `y`, hold, stage-1 valid, `data_out`, `valid_out`, and `frame_done` all clear to 0.
  - Line buffer contents are don't-care, because they are always overwritten in an even row before being read.
  - The first valid pixel after reset is treated as (0,0).

## Timing
- Latency: the window-completing pixel sampled with `valid_in`=1 at edge N produces `valid_out`=1 after edge N+2, for one cycle.
- Throughput: one pixel per cycle with `valid_in` held high continuously. Any gap pattern is accepted, e.g. the calc stage's every-other-cycle toggling valid.
- Outputs per map: exactly (ROW_LEN/2)·(COL_LEN/2) = 16 strobes at default parameters, emitted during odd rows only.
- Reset values: `data_out`=0, `valid_out`=0, `frame_done`=0.
- Deasserting `rst` takes effect at the next rising edge; no output strobe occurs in the first two cycles after release.

## Configuration
- **`CONV2_BIAS_EN` defined:** the stage-1 adder includes BIAS, and the adder path is IN_W+1 bits wide.
- **`CONV2_BIAS_EN` undefined:**
  - No adder is synthesised; sum = `conv_in` sign-extended, and BIAS is ignored.
  - Latency, counters, and pooling are identical to the enabled build.

## Test plan
- **Ramp:** `conv_in` = 8y+x with `valid_in` held high, BIAS=0 -> `data_out` = 9, 11, 13, 15, 25, …, 63, i.e. 16 strobes. `frame_done` fires with 63, two cycles after pixel (7,7).
- **All negative:** every `conv_in` = -100 -> 16 strobes, all `data_out`=0.
- **Saturation:** every `conv_in` = 8191 -> 16 strobes, all `data_out`=2047. A window of {5, 2047, 2048, 0} outputs 2047.
- **Sparse valid:** ramp delivered with `valid_in` toggling every other cycle -> identical 16 values. Each strobe comes two edges after its completing pixel.
- **Reset mid-frame:** assert `rst` after 20 pixels, release, then send the full ramp -> exactly 16 outputs matching the Ramp case. No strobe from the aborted frame.
- **Bias:** `CONV2_BIAS_EN` defined, BIAS=-10, ramp input -> outputs 0, 1, 3, 5, 15, …, 53. Same stimulus with the macro undefined -> matches the Ramp case.

Source files
------------

// File: rtl/conv2_relu_pool.sv
// conv2 post-processing: optional bias, ReLU, then 2x2 stride-2 max pooling with saturation.
// Optional feature: define CONV2_BIAS_EN to include the BIAS adder in stage 1.
module conv2_relu_pool #(
   parameter int                     IN_W    = 14,
   parameter int                     OUT_W   = 12,
   parameter int                     ROW_LEN = 8,
   parameter int                     COL_LEN = 8,
   parameter logic signed [IN_W-1:0] BIAS    = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    valid_in,
   input  logic signed [IN_W-1:0]  conv_in,
   output logic signed [OUT_W-1:0] data_out,
   output logic                    valid_out,
   output logic                    frame_done
);

   localparam int XW    = $clog2(ROW_LEN);
   localparam int YW    = $clog2(COL_LEN);
   localparam int LB_N  = ROW_LEN / 2;
   localparam int LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;

   localparam logic [XW-1:0]   X_LAST  = XW'(ROW_LEN - 1);
   localparam logic [YW-1:0]   Y_LAST  = YW'(COL_LEN - 1);
   localparam logic [IN_W-1:0] SAT_MAX = IN_W'((1 << (OUT_W - 1)) - 1);

   function automatic logic [IN_W-1:0] max2(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // Post-ReLU values are never negative, so they are carried as unsigned IN_W-bit magnitudes.
   logic signed [IN_W:0] sum;
   logic [IN_W-1:0]      relu;

`ifdef CONV2_BIAS_EN
   assign sum = $signed({conv_in[IN_W-1], conv_in}) + $signed({BIAS[IN_W-1], BIAS});
`else
   assign sum = {conv_in[IN_W-1], conv_in};
`endif
   assign relu = sum[IN_W] ? '0 : sum[IN_W-1:0];

   logic            s1_valid;
   logic [IN_W-1:0] s1_pix;

   // NOTE: every clocked block uses non-blocking assignments so all stages sample pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_pix   <= '0;
      end else begin
         s1_valid <= valid_in;
         if (valid_in) s1_pix <= relu;
      end
   end

   logic [XW-1:0]    x;
   logic [YW-1:0]    y;
   logic [IN_W-1:0]  hold;
   logic [IN_W-1:0]  linebuf [LB_N];
   logic [LB_AW-1:0] lb_idx;
   logic             em_valid;
   logic             em_last;
   logic [IN_W-1:0]  em_val;

   assign lb_idx = LB_AW'(x >> 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x        <= '0;
         y        <= '0;
         hold     <= '0;
         em_valid <= 1'b0;
         em_last  <= 1'b0;
         em_val   <= '0;
      end else begin
         em_valid <= 1'b0;
         em_last  <= 1'b0;
         if (s1_valid) begin
            if (!y[0]) begin
               if (!x[0]) hold <= s1_pix;
            end else if (!x[0]) begin
               hold <= max2(linebuf[lb_idx], s1_pix);
            end else begin
               em_val   <= max2(hold, s1_pix);
               em_valid <= 1'b1;
               em_last  <= (x == X_LAST) && (y == Y_LAST);
            end

            if (x == X_LAST) begin
               x <= '0;
               y <= (y == Y_LAST) ? '0 : y + 1'b1;
            end else begin
               x <= x + 1'b1;
            end
         end
      end
   end

   // NOTE: the line buffer has no reset; each entry is written in an even row before any odd-row read.
   always_ff @(posedge clk) begin
      if (s1_valid && !y[0] && x[0]) linebuf[lb_idx] <= max2(hold, s1_pix);
   end

   logic [OUT_W-1:0] sat_val;
   assign sat_val = (em_val > SAT_MAX) ? SAT_MAX[OUT_W-1:0] : em_val[OUT_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out   <= '0;
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         valid_out  <= em_valid;
         frame_done <= em_valid && em_last;
         if (em_valid) data_out <= sat_val;
      end
   end

endmodule

// File: tb/tb_conv2_relu_pool.sv
// Self-checking bench for conv2_relu_pool: window table, ramp, negative, saturation,
// sparse-valid and mid-frame reset frames against a scoreboard with exact 2-edge latency.
module tb_conv2_relu_pool;

   localparam int IN_W  = 14;
   localparam int OUT_W = 12;
`ifdef CONV2_BIAS_EN
   localparam int EB = -10;
`else
   localparam int EB = 0;
`endif

   logic                    clk;
   logic                    rst;
   logic                    valid_in;
   logic signed [IN_W-1:0]  conv_in;
   logic signed [OUT_W-1:0] data_out;
   logic                    valid_out;
   logic                    frame_done;

   conv2_relu_pool #(
      .IN_W(IN_W), .OUT_W(OUT_W), .ROW_LEN(8), .COL_LEN(8), .BIAS(-14'sd10)
   ) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .conv_in(conv_in),
      .data_out(data_out), .valid_out(valid_out), .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int val;
      int last;
      int due;
   } exp_t;

   typedef struct {
      int a, b, c, d;   // top-left, top-right, bottom-left, bottom-right
      int exp0;         // expected without bias
      int expb;         // expected with bias -10
   } win_t;

   exp_t sb[$];
   int   frame   [64];
   int   exp_arr [16];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int relu_sat(input int v);
      int r;
      r = v + EB;
      if (r < 0) r = 0;
      if (r > 2047) r = 2047;
      return r;
   endfunction

   function automatic int pool4(input int a, input int b, input int c, input int d);
      int m;
      m = relu_sat(a);
      if (relu_sat(b) > m) m = relu_sat(b);
      if (relu_sat(c) > m) m = relu_sat(c);
      if (relu_sat(d) > m) m = relu_sat(d);
      return m;
   endfunction

   task automatic model_frame();
      for (int k = 0; k < 16; k++) begin
         int base;
         base = (k / 4) * 16 + (k % 4) * 2;
         exp_arr[k] = pool4(frame[base], frame[base + 1], frame[base + 8], frame[base + 9]);
      end
   endtask

   // Drives the first n pixels of frame[]; pushes an expectation for every completed window.
   task automatic send_frame(input bit sparse, input int n);
      for (int idx = 0; idx < n; idx++) begin
         int px, py;
         if (sparse) begin
            @(negedge clk);
            valid_in = 1'b0;
         end
         @(negedge clk);
         valid_in = 1'b1;
         conv_in  = IN_W'(frame[idx]);
         px = idx % 8;
         py = idx / 8;
         if ((px % 2 == 1) && (py % 2 == 1))
            sb.push_back('{val: exp_arr[(py / 2) * 4 + px / 2], last: int'(idx == 63), due: cyc + 3});
      end
      @(negedge clk);
      valid_in = 1'b0;
   endtask

   // Output monitor: samples 1 time unit after each rising edge.
   initial begin
      forever begin
         bit   exp_strobe;
         exp_t e;
         @(posedge clk);
         #1;
         exp_strobe = (sb.size() > 0) && (sb[0].due == cyc);
         check("valid_out", int'(valid_out), int'(exp_strobe));
         if (exp_strobe) begin
            e = sb.pop_front();
            check("data_out", int'(data_out), e.val);
            check("frame_done", int'(frame_done), e.last);
         end else begin
            check("frame_done_idle", int'(frame_done), 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   win_t tbl [16];

   initial begin
      tbl[0]  = '{5, 2047, 2048, 0, 2047, 2038};
      tbl[1]  = '{-1, -2, -3, -4, 0, 0};
      tbl[2]  = '{0, 0, 0, 0, 0, 0};
      tbl[3]  = '{100, 3, 7, 1, 100, 90};
      tbl[4]  = '{1, 200, 3, 4, 200, 190};
      tbl[5]  = '{1, 2, 300, 4, 300, 290};
      tbl[6]  = '{1, 2, 3, 400, 400, 390};
      tbl[7]  = '{-8192, 8191, 0, 0, 2047, 2047};
      tbl[8]  = '{2046, 2047, 2045, -5, 2047, 2037};
      tbl[9]  = '{2049, 0, 0, 0, 2047, 2039};
      tbl[10] = '{9, 9, 9, 9, 9, 0};
      tbl[11] = '{12, -50, 11, 10, 12, 2};
      tbl[12] = '{-8192, -8192, -8192, -8192, 0, 0};
      tbl[13] = '{4095, 1, 1, 1, 2047, 2047};
      tbl[14] = '{7, 3, -7, 6, 7, 0};
      tbl[15] = '{1000, 1001, 999, 1002, 1002, 992};

      rst      = 1'b0;
      valid_in = 1'b0;
      conv_in  = '0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_data_out", int'(data_out), 0);
      check("reset_valid_out", int'(valid_out), 0);
      check("reset_frame_done", int'(frame_done), 0);
      rst = 1'b0;

      // Window table mapped onto one frame.
      for (int k = 0; k < 16; k++) begin
         int base;
         base = (k / 4) * 16 + (k % 4) * 2;
         frame[base]     = tbl[k].a;
         frame[base + 1] = tbl[k].b;
         frame[base + 8] = tbl[k].c;
         frame[base + 9] = tbl[k].d;
         exp_arr[k]      = (EB == 0) ? tbl[k].exp0 : tbl[k].expb;
      end
      send_frame(1'b0, 64);

      // Ramp 8y+x, back to back.
      for (int i = 0; i < 64; i++) frame[i] = i;
      model_frame();
      send_frame(1'b0, 64);

      // All negative.
      for (int i = 0; i < 64; i++) frame[i] = -100;
      model_frame();
      send_frame(1'b0, 64);

      // Saturation.
      for (int i = 0; i < 64; i++) frame[i] = 8191;
      model_frame();
      send_frame(1'b0, 64);

      // Sparse-valid ramp.
      for (int i = 0; i < 64; i++) frame[i] = i;
      model_frame();
      send_frame(1'b1, 64);

      // Reset after 20 ramp pixels, then a full ramp.
      send_frame(1'b0, 20);
      repeat (4) @(negedge clk);
      check("pre_reset_data_out", int'(data_out), (EB == 0) ? 15 : 5);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("midreset_data_out", int'(data_out), 0);
      check("midreset_valid_out", int'(valid_out), 0);
      check("midreset_frame_done", int'(frame_done), 0);
      rst = 1'b0;
      send_frame(1'b0, 64);

      repeat (6) @(negedge clk);
      check("pending_outputs", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
